// File: rtl/ex_muldiv_unit_if.sv
// EX-stage mul/div handshake bundle: issue/move/flush controls from EX,
// HI/LO, busy/stall and completion status back from the unit.
interface ex_muldiv_unit_if #(
   parameter int DATA_W = 32
);
   logic              i_start;
   logic [1:0]        i_op;
   logic [DATA_W-1:0] i_Aoperand;
   logic [DATA_W-1:0] i_Boperand;
   logic              i_mthi;
   logic              i_mtlo;
   logic              i_hilo_req;
   logic              i_flush;
   logic [DATA_W-1:0] o_hi;
   logic [DATA_W-1:0] o_lo;
   logic              o_busy;
   logic              o_stall;
   logic              o_done;
   logic              o_div_by_zero;

   modport master (
      output i_start, i_op, i_Aoperand, i_Boperand,
      output i_mthi, i_mtlo, i_hilo_req, i_flush,
      input  o_hi, o_lo, o_busy, o_stall, o_done, o_div_by_zero
   );

   modport slave (
      input  i_start, i_op, i_Aoperand, i_Boperand,
      input  i_mthi, i_mtlo, i_hilo_req, i_flush,
      output o_hi, o_lo, o_busy, o_stall, o_done, o_div_by_zero
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed DATA_W+1 cycle
// busy window. Ports: i_clk, i_rst_n, bus (slave side of ex_muldiv_unit_if).
module ex_muldiv_unit #(
   parameter int DATA_W = 32
) (
   input logic i_clk,
   input logic i_rst_n,
   ex_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] hi_q, lo_q;
   logic [DATA_W-1:0] hw, lw, bw;
   logic              is_div, neg_res, neg_rem, div0;
   logic              busy_q, done_q, dz_q;

   logic              sgn;
   logic [DATA_W-1:0] a_abs, b_abs;
   logic [DATA_W:0]   mul_sum;
   logic [DATA_W:0]   div_r;
   logic [DATA_W+1:0] div_diff;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0] quo, rem;

   always_comb begin
      sgn   = ~bus.i_op[0];
      a_abs = (sgn & bus.i_Aoperand[DATA_W-1]) ? -bus.i_Aoperand
                                                : bus.i_Aoperand;
      b_abs = (sgn & bus.i_Boperand[DATA_W-1]) ? -bus.i_Boperand
                                                : bus.i_Boperand;
      // Multiply: lw holds the multiplier, shifted out LSB first while the
      // partial product shifts into it from hw.
      mul_sum = {1'b0, hw} + (lw[0] ? {1'b0, bw} : '0);
      // Restoring divide: lw holds the dividend, quotient bits shift in.
      div_r    = {hw, lw[DATA_W-1]};
      div_diff = {1'b0, div_r} - {2'b0, bw};
      prod = neg_res ? -{hw, lw} : {hw, lw};
      quo  = neg_res ? -lw : lw;
      rem  = neg_rem ? -hw : hw;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         hw      <= '0;
         lw      <= '0;
         bw      <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.i_flush) begin
                  if (bus.i_mthi) hi_q <= bus.i_Aoperand;
                  if (bus.i_mtlo) lo_q <= bus.i_Aoperand;
                  if (bus.i_start) begin
                     state   <= RUN;
                     busy_q  <= 1'b1;
                     cnt     <= CW'(DATA_W);
                     hw      <= '0;
                     lw      <= a_abs;
                     bw      <= b_abs;
                     is_div  <= bus.i_op[1];
                     neg_res <= sgn & (bus.i_Aoperand[DATA_W-1]
                                     ^ bus.i_Boperand[DATA_W-1]);
                     neg_rem <= sgn & bus.i_Aoperand[DATA_W-1];
                     div0    <= bus.i_op[1] & (bus.i_Boperand == '0);
                  end
               end
            end
            RUN: begin
               if (bus.i_flush) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  if (is_div) begin
                     if (!div_diff[DATA_W+1]) begin
                        hw <= div_diff[DATA_W-1:0];
                        lw <= {lw[DATA_W-2:0], 1'b1};
                     end else begin
                        hw <= div_r[DATA_W-1:0];
                        lw <= {lw[DATA_W-2:0], 1'b0};
                     end
                  end else begin
                     hw <= mul_sum[DATA_W:1];
                     lw <= {mul_sum[0], lw[DATA_W-1:1]};
                  end
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1)) state <= FIX;
               end
            end
            FIX: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               if (!bus.i_flush) begin
                  done_q <= 1'b1;
                  dz_q   <= div0;
                  if (!is_div) begin
                     hi_q <= prod[2*DATA_W-1:DATA_W];
                     lo_q <= prod[DATA_W-1:0];
                  end else if (!div0) begin
                     hi_q <= rem;
                     lo_q <= quo;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_hi          = hi_q;
   assign bus.o_lo          = lo_q;
   assign bus.o_busy        = busy_q;
   assign bus.o_stall       = busy_q & bus.i_hilo_req;
   assign bus.o_done        = done_q;
   assign bus.o_div_by_zero = dz_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: table of mul/div vectors plus
// hand sequences for moves, div-by-zero, stall, flush and async reset.
module tb_ex_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit_if #(.DATA_W(32)) bus ();

   ex_muldiv_unit #(.DATA_W(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Issues one op and returns edges from accept to o_done (999 on timeout).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
      bus.i_start    = 1'b1;
      bus.i_op       = op;
      bus.i_Aoperand = a;
      bus.i_Boperand = b;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      lat = 999;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (bus.o_done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic move(input logic hi, input logic lo,
                       input logic [31:0] d);
      bus.i_mthi     = hi;
      bus.i_mtlo     = lo;
      bus.i_Aoperand = d;
      @(posedge clk); #1;
      bus.i_mthi = 1'b0;
      bus.i_mtlo = 1'b0;
   endtask

   initial begin
      int lat;
      int cnt;
      vecs[0] = '{2'b00, 32'hFFFFFFFE, 32'h3,
                  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{2'b11, 32'd7, 32'd2, 32'd1, 32'd3};
      vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
                  32'h0, 32'h80000000};
      vecs[5] = '{2'b00, 32'd5, 32'hFFFFFFFC,
                  32'hFFFFFFFF, 32'hFFFFFFEC};
      vecs[6] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14};
      vecs[7] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
      vecs[8] = '{2'b01, 32'h80000000, 32'd2, 32'd1, 32'd0};

      bus.i_start    = 1'b0;
      bus.i_op       = 2'b00;
      bus.i_Aoperand = '0;
      bus.i_Boperand = '0;
      bus.i_mthi     = 1'b0;
      bus.i_mtlo     = 1'b0;
      bus.i_hilo_req = 1'b0;
      bus.i_flush    = 1'b0;

      #2;
      check("rst_hi", 64'(bus.o_hi), 64'h0);
      check("rst_lo", 64'(bus.o_lo), 64'h0);
      check("rst_flags", 64'({bus.o_busy, bus.o_done,
            bus.o_div_by_zero, bus.o_stall}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_lat", i), 64'(lat), 64'd33);
         check($sformatf("v%0d_hi", i), 64'(bus.o_hi), 64'(vecs[i].hi));
         check($sformatf("v%0d_lo", i), 64'(bus.o_lo), 64'(vecs[i].lo));
         check($sformatf("v%0d_dz", i), 64'(bus.o_div_by_zero), 64'h0);
      end

      move(1'b1, 1'b0, 32'h11111111);
      move(1'b0, 1'b1, 32'h22222222);
      check("mthi", 64'(bus.o_hi), 64'h11111111);
      check("mtlo", 64'(bus.o_lo), 64'h22222222);
      run_op(2'b10, 32'd5, 32'd0, lat);
      check("dz_lat", 64'(lat), 64'd33);
      check("dz_flag", 64'(bus.o_div_by_zero), 64'h1);
      check("dz_hi", 64'(bus.o_hi), 64'h11111111);
      check("dz_lo", 64'(bus.o_lo), 64'h22222222);
      @(posedge clk); #1;
      check("dz_pulse", 64'({bus.o_done, bus.o_div_by_zero}), 64'h0);

      // Stall window, with a second start and a move while busy.
      bus.i_hilo_req = 1'b1;
      bus.i_start    = 1'b1;
      bus.i_op       = 2'b01;
      bus.i_Aoperand = 32'd6;
      bus.i_Boperand = 32'd7;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      cnt = 0;
      lat = 999;
      for (int k = 0; k < 60; k++) begin
         if (bus.o_stall) cnt++;
         if (bus.o_done) begin
            lat = k;
            break;
         end
         bus.i_start = (k == 3);
         bus.i_mthi  = (k == 5);
         bus.i_op       = 2'b11;
         bus.i_Aoperand = 32'hDEAD;
         bus.i_Boperand = 32'd0;
         @(posedge clk); #1;
      end
      bus.i_start    = 1'b0;
      bus.i_mthi     = 1'b0;
      bus.i_hilo_req = 1'b0;
      check("stall_cnt", 64'(cnt), 64'd33);
      check("stall_lat", 64'(lat), 64'd33);
      check("stall_hi", 64'(bus.o_hi), 64'h0);
      check("stall_lo", 64'(bus.o_lo), 64'd42);
      check("stall_dz", 64'(bus.o_div_by_zero), 64'h0);
      @(posedge clk); #1;
      check("stall_idle", 64'(bus.o_busy), 64'h0);

      // Flush at RUN cycle 10.
      bus.i_start    = 1'b1;
      bus.i_op       = 2'b00;
      bus.i_Aoperand = 32'd3;
      bus.i_Boperand = 32'd3;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("fl_busy_pre", 64'(bus.o_busy), 64'h1);
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      check("fl_busy", 64'(bus.o_busy), 64'h0);
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus.o_done) cnt++;
         @(posedge clk); #1;
      end
      check("fl_done", 64'(cnt), 64'h0);
      check("fl_hi", 64'(bus.o_hi), 64'h0);
      check("fl_lo", 64'(bus.o_lo), 64'd42);

      // Async reset mid-op.
      move(1'b1, 1'b0, 32'h12345678);
      bus.i_start    = 1'b1;
      bus.i_op       = 2'b01;
      bus.i_Aoperand = 32'd5;
      bus.i_Boperand = 32'd5;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("ar_hi", 64'(bus.o_hi), 64'h0);
      check("ar_lo", 64'(bus.o_lo), 64'h0);
      check("ar_flags", 64'({bus.o_busy, bus.o_done}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(2'b00, 32'hFFFFFFFE, 32'd3, lat);
      check("ar_lat", 64'(lat), 64'd33);
      check("ar_res", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFF_FFFFFFFA);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
